mac_engine: RTL and testbench

MAC_ENGINE -- requirements
Module: mac_engine

---
 rtl/mac_package.sv | 28 ++
 rtl/mac_engine.sv | 136 +++++++++++++
 tb/tb_mac_engine.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_package.sv
// Shared types for the multiply-accumulate engine:
// control/flag bundles, FSM states and the job-length bound.
package mac_package;

    localparam int MAC_CNT_LEN = 1024;
    localparam int CNT_W       = $clog2(MAC_CNT_LEN) + 1;

    typedef struct packed {
        logic             start;
        logic             simple_mul;
        logic [CNT_W-1:0] len;
        logic [5:0]       shift;
    } ctrl_engine_t;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } flags_engine_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WAIT_C,
        OUT
    } mac_state_e;

endpackage

// File: rtl/mac_engine.sv
// Streaming signed multiply-accumulate engine: consumes a/b pairs,
// optionally adds a c bias, and emits shifted results on d.
module mac_engine
    import mac_package::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [DATA_WIDTH-1:0]   b_data_i,
    input  logic                    c_valid_i,
    output logic                    c_ready_o,
    input  logic [DATA_WIDTH-1:0]   c_data_i,
    output logic                    d_valid_o,
    input  logic                    d_ready_i,
    output logic [DATA_WIDTH-1:0]   d_data_o,
    output logic [DATA_WIDTH/8-1:0] d_strb_o,
    input  ctrl_engine_t            ctrl_i,
    output flags_engine_t           flags_o
);

    localparam int DW2 = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mac_state_e              state_q;
    logic signed [DW2-1:0]   acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   d_data_q;
    logic                    done_q;
    logic                    mul_q;
    logic [CNT_W-1:0]        len_q;
    logic [5:0]              shift_q;

    logic signed [DW2-1:0]   a_ext;
    logic signed [DW2-1:0]   b_ext;
    logic signed [DW2-1:0]   c_ext;
    logic signed [DW2-1:0]   prod;
    logic signed [DW2-1:0]   prod_sh;
    logic signed [DW2-1:0]   acc_sh;
    logic signed [DW2-1:0]   bias_sum;
    logic                    pair_hs;
    logic                    last_cnt;

    always_comb begin
        a_ext    = {{DATA_WIDTH{a_data_i[DATA_WIDTH-1]}}, a_data_i};
        b_ext    = {{DATA_WIDTH{b_data_i[DATA_WIDTH-1]}}, b_data_i};
        c_ext    = {{DATA_WIDTH{c_data_i[DATA_WIDTH-1]}}, c_data_i};
        prod     = a_ext * b_ext;
        prod_sh  = prod >>> shift_q;
        acc_sh   = acc_q >>> shift_q;
        bias_sum = acc_sh + c_ext;
    end

    // a and b are only ever taken together, and only while enabled
    assign pair_hs   = enable_i && (state_q == ACC) && a_valid_i && b_valid_i;
    assign a_ready_o = pair_hs;
    assign b_ready_o = pair_hs;
    assign c_ready_o = enable_i && (state_q == WAIT_C);
    assign d_valid_o = (state_q == OUT);
    assign d_data_o  = d_data_q;
    assign d_strb_o  = '1;
    assign last_cnt  = (cnt_q == len_q);

    always_comb begin
        flags_o      = '0;
        flags_o.busy = (state_q != IDLE);
        flags_o.done = done_q;
        flags_o.cnt  = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            d_data_q <= '0;
            done_q   <= 1'b0;
            mul_q    <= 1'b0;
            len_q    <= '0;
            shift_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (enable_i) begin
                unique case (state_q)
                    IDLE: begin
                        if (ctrl_i.start) begin
                            state_q <= ACC;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            mul_q   <= ctrl_i.simple_mul;
                            len_q   <= ctrl_i.len;
                            shift_q <= ctrl_i.shift;
                        end
                    end
                    ACC: begin
                        if (pair_hs) begin
                            if (mul_q) begin
                                d_data_q <= prod_sh[DATA_WIDTH-1:0];
                                state_q  <= OUT;
                            end else begin
                                acc_q <= acc_q + prod;
                                cnt_q <= cnt_q + CNT_ONE;
                                if (last_cnt) state_q <= WAIT_C;
                            end
                        end
                    end
                    WAIT_C: begin
                        if (c_valid_i) begin
                            d_data_q <= bias_sum[DATA_WIDTH-1:0];
                            state_q  <= OUT;
                        end
                    end
                    OUT: begin
                        if (d_ready_i) begin
                            if (mul_q && !last_cnt) begin
                                cnt_q   <= cnt_q + CNT_ONE;
                                state_q <= ACC;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_engine.sv
// Directed self-checking bench for mac_engine.
module tb_mac_engine;
    import mac_package::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          clear_i;
    logic          a_valid_i, a_ready_o;
    logic [31:0]   a_data_i;
    logic          b_valid_i, b_ready_o;
    logic [31:0]   b_data_i;
    logic          c_valid_i, c_ready_o;
    logic [31:0]   c_data_i;
    logic          d_valid_o, d_ready_i;
    logic [31:0]   d_data_o;
    logic [3:0]    d_strb_o;
    ctrl_engine_t  ctrl_i;
    flags_engine_t flags_o;

    int checks = 0;
    int errors = 0;
    bit c_seen = 1'b0;

    mac_engine #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .enable_i(enable_i), .clear_i(clear_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
        .c_valid_i(c_valid_i), .c_ready_o(c_ready_o), .c_data_i(c_data_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
        .d_strb_o(d_strb_o), .ctrl_i(ctrl_i), .flags_o(flags_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (c_ready_o) c_seen = 1'b1;

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input bit mul, input int len, input int sh);
        ctrl_i.start      = 1'b1;
        ctrl_i.simple_mul = mul;
        ctrl_i.len        = CNT_W'(len);
        ctrl_i.shift      = 6'(sh);
        tick();
        ctrl_i.start = 1'b0;
    endtask

    task automatic send_pair(input int a, input int b, output bit ok);
        a_data_i = 32'(a);
        b_data_i = 32'(b);
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (a_ready_o && b_ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic send_c(input int c, output bit ok);
        c_data_i = 32'(c);
        c_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (c_ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        c_valid_i = 1'b0;
    endtask

    task automatic recv_d(output logic [31:0] data, output bit ok);
        d_ready_i = 1'b1;
        ok = 1'b0;
        data = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (d_valid_o) begin
                data = d_data_o;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        d_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        c_valid_i = 1'b1;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++;
        if ({a_ready_o, b_ready_o, c_ready_o, d_valid_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 0000",
                     {a_ready_o, b_ready_o, c_ready_o, d_valid_o});
        end
        checks++;
        if ({flags_o.busy, flags_o.done} !== 2'b00 || flags_o.cnt !== '0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b cnt=%0d want 0 0 0",
                     flags_o.busy, flags_o.done, flags_o.cnt);
        end
        checks++;
        if (d_data_o !== 32'd0 || d_strb_o !== 4'hf) begin
            errors++;
            $display("FAIL reset_data: got %h strb %h want 0 strb f",
                     d_data_o, d_strb_o);
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        c_valid_i = 1'b0;
    endtask

    task automatic test_accumulate();
        bit ok, all_ok;
        logic [31:0] d;
        int av[4] = '{1, 2, 3, 4};
        int bv[4] = '{5, 6, 7, 8};
        start_job(1'b0, 3, 0);
        checks++;
        if (flags_o.busy !== 1'b1) begin
            errors++;
            $display("FAIL acc_busy: got %b want 1", flags_o.busy);
        end
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pair(av[i], bv[i], ok);
            all_ok &= ok;
        end
        send_c(10, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok || d_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL acc_latency: got ok=%b valid=%b want 1 1",
                     all_ok, d_valid_o);
        end
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'd80) begin
            errors++;
            $display("FAIL acc_result: got %0d ok=%b want 80", $signed(d), ok);
        end
        checks++;
        if (flags_o.done !== 1'b1 || flags_o.busy !== 1'b0) begin
            errors++;
            $display("FAIL acc_done: got done=%b busy=%b want 1 0",
                     flags_o.done, flags_o.busy);
        end
        tick();
        checks++;
        if (flags_o.done !== 1'b0) begin
            errors++;
            $display("FAIL acc_done_pulse: got %b want 0", flags_o.done);
        end
    endtask

    task automatic test_simple_mul();
        bit ok;
        logic [31:0] d;
        int av[3] = '{16, -32, 48};
        int ex[3] = '{2, -4, 6};
        c_seen = 1'b0;
        start_job(1'b1, 2, 4);
        for (int i = 0; i < 3; i++) begin
            send_pair(av[i], 2, ok);
            recv_d(d, ok);
            checks++;
            if (!ok || d !== 32'(ex[i])) begin
                errors++;
                $display("FAIL mul_result[%0d]: got %0d want %0d",
                         i, $signed(d), ex[i]);
            end
        end
        checks++;
        if (c_seen !== 1'b0 || flags_o.done !== 1'b1) begin
            errors++;
            $display("FAIL mul_c_unused: got c_seen=%b done=%b want 0 1",
                     c_seen, flags_o.done);
        end
    endtask

    task automatic test_shift_limit();
        bit ok;
        logic [31:0] d;
        start_job(1'b1, 1, 63);
        send_pair(-1, 1, ok);
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'hffff_ffff) begin
            errors++;
            $display("FAIL shift_neg: got %h want ffffffff", d);
        end
        send_pair(5, 1, ok);
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'd0) begin
            errors++;
            $display("FAIL shift_pos: got %h want 0", d);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [31:0] d;
        int bad;
        start_job(1'b1, 0, 0);
        send_pair(3, 4, ok);
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (d_valid_o !== 1'b1 || d_data_o !== 32'd12 || a_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0d a_ready=%b want 1 12 0",
                         i, d_valid_o, d_data_o, a_ready_o);
            end
            tick();
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'd12 || d_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_transfer: got %0d valid_after=%b want 12 0",
                     d, d_valid_o);
        end
    endtask

    task automatic test_skew();
        bit ok;
        logic [31:0] d;
        start_job(1'b0, 0, 0);
        a_data_i = 32'hffff_fff9;
        a_valid_i = 1'b1;
        b_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready_o !== 1'b0 || flags_o.cnt !== '0) begin
                errors++;
                $display("FAIL skew_wait[%0d]: got a_ready=%b cnt=%0d want 0 0",
                         i, a_ready_o, flags_o.cnt);
            end
            tick();
        end
        send_pair(-7, 3, ok);
        send_c(1, ok);
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'hffff_ffec) begin
            errors++;
            $display("FAIL skew_result: got %0d want -20", $signed(d));
        end
    endtask

    task automatic test_clear_reset();
        bit ok;
        logic [31:0] d;
        int seen;
        for (int mode = 0; mode < 2; mode++) begin
            start_job(1'b0, 3, 0);
            send_pair(1, 1, ok);
            send_pair(2, 2, ok);
            if (mode == 0) clear_i = 1'b1;
            else rst_i = 1'b1;
            tick();
            clear_i = 1'b0;
            rst_i = 1'b0;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                #1;
                if (d_valid_o) seen++;
                tick();
            end
            checks++;
            if (flags_o.busy !== 1'b0 || flags_o.cnt !== '0 || d_data_o !== 32'd0 || seen != 0) begin
                errors++;
                $display("FAIL abort_mode%0d: got busy=%b cnt=%0d data=%0d d_seen=%0d want 0 0 0 0",
                         mode, flags_o.busy, flags_o.cnt, d_data_o, seen);
            end
        end
        start_job(1'b0, 0, 0);
        send_pair(2, 2, ok);
        send_c(0, ok);
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'd4) begin
            errors++;
            $display("FAIL abort_restart: got %0d want 4", $signed(d));
        end
    endtask

    task automatic test_enable_freeze();
        bit ok;
        logic [31:0] d;
        start_job(1'b0, 3, 1);
        send_pair(1, 5, ok);
        send_pair(2, 6, ok);
        a_data_i = 32'd3;
        b_data_i = 32'd7;
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready_o !== 1'b0 || flags_o.cnt !== CNT_W'(2) || flags_o.busy !== 1'b1) begin
                errors++;
                $display("FAIL en_freeze[%0d]: got a_ready=%b cnt=%0d busy=%b want 0 2 1",
                         i, a_ready_o, flags_o.cnt, flags_o.busy);
            end
            tick();
        end
        enable_i = 1'b1;
        send_pair(3, 7, ok);
        send_pair(4, 8, ok);
        send_c(10, ok);
        recv_d(d, ok);
        checks++;
        if (!ok || d !== 32'd45) begin
            errors++;
            $display("FAIL en_result: got %0d want 45", $signed(d));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        enable_i = 1'b1;
        clear_i = 1'b0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        c_valid_i = 1'b0;
        d_ready_i = 1'b0;
        a_data_i = '0;
        b_data_i = '0;
        c_data_i = '0;
        ctrl_i = '0;
        #1;
        test_reset();
        test_accumulate();
        test_simple_mul();
        test_shift_limit();
        test_back_pressure();
        test_skew();
        test_clear_reset();
        test_enable_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
